// File: rtl/rl_lj_pair_feeder_if.sv
// Pair stream between the LJ pair feeder (master) and the LJ evaluator (slave).
// Carries a valid/ready handshake with the reference and neighbor coordinates.
interface rl_lj_pair_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pair_valid;
    logic                  pair_ready;
    logic                  pair_last;
    logic [DATA_WIDTH-1:0] ref_x;
    logic [DATA_WIDTH-1:0] ref_y;
    logic [DATA_WIDTH-1:0] ref_z;
    logic [DATA_WIDTH-1:0] neighbor_x;
    logic [DATA_WIDTH-1:0] neighbor_y;
    logic [DATA_WIDTH-1:0] neighbor_z;

    modport master (
        output pair_valid, pair_last,
        output ref_x, ref_y, ref_z,
        output neighbor_x, neighbor_y, neighbor_z,
        input  pair_ready
    );

    modport slave (
        input  pair_valid, pair_last,
        input  ref_x, ref_y, ref_z,
        input  neighbor_x, neighbor_y, neighbor_z,
        output pair_ready
    );
endinterface

// File: rtl/rl_lj_pair_feeder.sv
// Streams (reference, neighbor) coordinate pairs from a local neighbor buffer
// into the LJ evaluator, one pair per cycle, with optional self-pair skip.
module rl_lj_pair_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  buf_wr_en,
    input  logic [ADDR_WIDTH-1:0] buf_wr_addr,
    input  logic [DATA_WIDTH-1:0] buf_wr_x,
    input  logic [DATA_WIDTH-1:0] buf_wr_y,
    input  logic [DATA_WIDTH-1:0] buf_wr_z,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_ref_x,
    input  logic [DATA_WIDTH-1:0] start_ref_y,
    input  logic [DATA_WIDTH-1:0] start_ref_z,
    input  logic [ADDR_WIDTH:0]   num_neighbors,
    input  logic                  skip_en,
    input  logic [ADDR_WIDTH-1:0] skip_index,
    rl_lj_pair_feeder_if.master   pair,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    typedef logic [ADDR_WIDTH:0] count_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem_x [DEPTH];
    logic [DATA_WIDTH-1:0] mem_y [DEPTH];
    logic [DATA_WIDTH-1:0] mem_z [DEPTH];

    logic [DATA_WIDTH-1:0] ref_x_q, ref_y_q, ref_z_q;
    logic [DATA_WIDTH-1:0] nb_x_q, nb_y_q, nb_z_q;
    count_t                n_q;
    logic                  skip_en_q;
    logic [ADDR_WIDTH-1:0] skip_idx_q;
    count_t                idx;
    logic                  valid_q;
    logic                  last_q;

    count_t start_n, start_first, stream_next;
    logic   handshake;
    logic   load_en;
    count_t load_idx;
    logic   load_last;

    // Index after idx, stepping over the skipped entry so no bubble appears.
    function automatic count_t next_index(input count_t cur, input logic en,
                                          input logic [ADDR_WIDTH-1:0] sk);
        count_t nx;
        nx = cur + count_t'(1);
        if (en && nx == {1'b0, sk})
            nx = cur + count_t'(2);
        return nx;
    endfunction

    always_comb begin
        start_n     = (num_neighbors > count_t'(DEPTH)) ? count_t'(DEPTH) : num_neighbors;
        start_first = (skip_en && skip_index == '0) ? count_t'(1) : '0;
        stream_next = next_index(idx, skip_en_q, skip_idx_q);
        handshake   = valid_q & pair.pair_ready;
    end

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        load_idx   = '0;
        load_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_first < start_n) begin
                        state_next = STREAM;
                        load_en    = 1'b1;
                        load_idx   = start_first;
                        load_last  = next_index(start_first, skip_en, skip_index) >= start_n;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (last_q) begin
                        state_next = DONE;
                    end else begin
                        load_en   = 1'b1;
                        load_idx  = stream_next;
                        load_last = next_index(stream_next, skip_en_q, skip_idx_q) >= n_q;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Buffer is deliberately outside the reset domain so its contents survive reset.
    always_ff @(posedge clock) begin
        if (buf_wr_en && state == IDLE) begin
            mem_x[buf_wr_addr] <= buf_wr_x;
            mem_y[buf_wr_addr] <= buf_wr_y;
            mem_z[buf_wr_addr] <= buf_wr_z;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ref_x_q    <= '0;
            ref_y_q    <= '0;
            ref_z_q    <= '0;
            nb_x_q     <= '0;
            nb_y_q     <= '0;
            nb_z_q     <= '0;
            n_q        <= '0;
            skip_en_q  <= 1'b0;
            skip_idx_q <= '0;
            idx        <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ref_x_q    <= start_ref_x;
                ref_y_q    <= start_ref_y;
                ref_z_q    <= start_ref_z;
                n_q        <= start_n;
                skip_en_q  <= skip_en;
                skip_idx_q <= skip_index;
            end
            if (load_en) begin
                idx     <= load_idx;
                nb_x_q  <= mem_x[load_idx[ADDR_WIDTH-1:0]];
                nb_y_q  <= mem_y[load_idx[ADDR_WIDTH-1:0]];
                nb_z_q  <= mem_z[load_idx[ADDR_WIDTH-1:0]];
                valid_q <= 1'b1;
                last_q  <= load_last;
            end else if (handshake) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign pair.pair_valid = valid_q;
    assign pair.pair_last  = last_q;
    assign pair.ref_x      = ref_x_q;
    assign pair.ref_y      = ref_y_q;
    assign pair.ref_z      = ref_z_q;
    assign pair.neighbor_x = nb_x_q;
    assign pair.neighbor_y = nb_y_q;
    assign pair.neighbor_z = nb_z_q;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_rl_lj_pair_feeder.sv
// Scoreboard bench for rl_lj_pair_feeder: expected pairs are queued from a
// buffer model when a stream is started and popped on each handshake.
module tb_rl_lj_pair_feeder;

    localparam logic [31:0] REF_VAL = 32'h3F80_0000;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        last;
    } pair_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        buf_wr_en;
    logic [5:0]  buf_wr_addr;
    logic [31:0] buf_wr_x, buf_wr_y, buf_wr_z;
    logic        start;
    logic [31:0] start_ref_x, start_ref_y, start_ref_z;
    logic [6:0]  num_neighbors;
    logic        skip_en;
    logic [5:0]  skip_index;
    logic        busy, done;

    logic [31:0] model_x [64];
    logic [31:0] model_y [64];
    logic [31:0] model_z [64];
    pair_t       exp_q[$];

    int checks = 0;
    int errors = 0;

    rl_lj_pair_feeder_if #(.DATA_WIDTH(32)) pair_bus ();

    rl_lj_pair_feeder #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_x      (buf_wr_x),
        .buf_wr_y      (buf_wr_y),
        .buf_wr_z      (buf_wr_z),
        .start         (start),
        .start_ref_x   (start_ref_x),
        .start_ref_y   (start_ref_y),
        .start_ref_z   (start_ref_z),
        .num_neighbors (num_neighbors),
        .skip_en       (skip_en),
        .skip_index    (skip_index),
        .pair          (pair_bus),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeEntry(input int addr, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] z);
        @(negedge clock);
        buf_wr_en   = 1'b1;
        buf_wr_addr = 6'(addr);
        buf_wr_x    = x;
        buf_wr_y    = y;
        buf_wr_z    = z;
        @(negedge clock);
        buf_wr_en = 1'b0;
        model_x[addr] = x;
        model_y[addr] = y;
        model_z[addr] = z;
    endtask

    // Runs one stream; stall holds ready low for the first cycles, inject fires
    // a start and a buffer write mid-stream, abort_after resets after that many handshakes.
    task automatic applyStimulus(input int n, input bit sk_en, input int sk_idx,
                                 input int stall, input bit inject, input int abort_after);
        int    nc;
        int    exp_n;
        int    hs;
        bit    finished;
        pair_t p;
        nc = (n > 64) ? 64 : n;
        exp_q.delete();
        for (int i = 0; i < nc; i++) begin
            if (!(sk_en && i == sk_idx)) begin
                p.x = model_x[i];
                p.y = model_y[i];
                p.z = model_z[i];
                p.last = 1'b0;
                exp_q.push_back(p);
            end
        end
        if (exp_q.size() > 0)
            exp_q[exp_q.size()-1].last = 1'b1;
        exp_n = exp_q.size();

        @(negedge clock);
        start         = 1'b1;
        start_ref_x   = REF_VAL;
        start_ref_y   = REF_VAL;
        start_ref_z   = REF_VAL;
        num_neighbors = 7'(n);
        skip_en       = sk_en;
        skip_index    = 6'(sk_idx);
        pair_bus.pair_ready = 1'b0;
        hs       = 0;
        finished = 1'b0;

        for (int c = 1; c <= 300 && !finished; c++) begin
            @(negedge clock);
            start     = 1'b0;
            buf_wr_en = 1'b0;
            if (exp_q.size() > 0) begin
                checkOutput("pair_valid", pair_bus.pair_valid, 1);
                checkOutput("done_early", done, 0);
                checkOutput("busy", busy, 1);
                if (pair_bus.pair_valid) begin
                    checkOutput("neighbor",
                                {pair_bus.neighbor_x, pair_bus.neighbor_y, pair_bus.neighbor_z},
                                {exp_q[0].x, exp_q[0].y, exp_q[0].z});
                    checkOutput("pair_last", pair_bus.pair_last, exp_q[0].last);
                    checkOutput("ref", {pair_bus.ref_x, pair_bus.ref_y, pair_bus.ref_z},
                                {REF_VAL, REF_VAL, REF_VAL});
                end
                pair_bus.pair_ready = (c > stall);
                if (pair_bus.pair_valid && pair_bus.pair_ready) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
                if (inject && c == 2) begin
                    start         = 1'b1;
                    start_ref_x   = 32'h4040_0000;
                    num_neighbors = 7'd5;
                    buf_wr_en     = 1'b1;
                    buf_wr_addr   = 6'd1;
                    buf_wr_x      = 32'hDEAD_BEEF;
                    buf_wr_y      = 32'hDEAD_BEEF;
                    buf_wr_z      = 32'hDEAD_BEEF;
                end
                if (abort_after > 0 && hs == abort_after) begin
                    @(posedge clock);
                    #1 resetn = 1'b0;
                    #1;
                    checkOutput("rst_valid", pair_bus.pair_valid, 0);
                    checkOutput("rst_busy", busy, 0);
                    checkOutput("rst_done", done, 0);
                    checkOutput("rst_last", pair_bus.pair_last, 0);
                    checkOutput("rst_coords", {pair_bus.ref_x, pair_bus.neighbor_x}, 0);
                    @(negedge clock);
                    pair_bus.pair_ready = 1'b0;
                    @(negedge clock);
                    resetn = 1'b1;
                    exp_q.delete();
                    finished = 1'b1;
                end
            end else begin
                checkOutput("done", done, 1);
                checkOutput("valid_after_last", pair_bus.pair_valid, 0);
                checkOutput("done_cycle", c, exp_n + stall + 1);
                @(negedge clock);
                checkOutput("done_pulse", done, 0);
                checkOutput("busy_idle", busy, 0);
                finished = 1'b1;
            end
        end
        if (!finished)
            checkOutput("done_timeout", 0, 1);
        pair_bus.pair_ready = 1'b0;
    endtask

    initial begin
        resetn              = 1'b0;
        buf_wr_en           = 1'b0;
        buf_wr_addr         = '0;
        buf_wr_x            = '0;
        buf_wr_y            = '0;
        buf_wr_z            = '0;
        start               = 1'b0;
        start_ref_x         = '0;
        start_ref_y         = '0;
        start_ref_z         = '0;
        num_neighbors       = '0;
        skip_en             = 1'b0;
        skip_index          = '0;
        pair_bus.pair_ready = 1'b0;

        #2;
        checkOutput("reset_valid", pair_bus.pair_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_last", pair_bus.pair_last, 0);
        checkOutput("reset_coords", {pair_bus.ref_x, pair_bus.neighbor_x, pair_bus.neighbor_z}, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        writeEntry(0, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        writeEntry(1, 32'h4080_0000, 32'h4080_0000, 32'h4080_0000);
        writeEntry(2, 32'h4000_0000, 32'h40A0_0000, 32'h4110_0000);

        $display("[TB] basic stream");
        applyStimulus(3, 1'b0, 0, 0, 1'b0, 0);
        $display("[TB] backpressure");
        applyStimulus(3, 1'b0, 0, 4, 1'b0, 0);
        $display("[TB] self-skip");
        applyStimulus(3, 1'b1, 1, 0, 1'b0, 0);
        applyStimulus(3, 1'b1, 2, 0, 1'b0, 0);
        $display("[TB] empty and degenerate lists");
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1, 1'b1, 0, 0, 1'b0, 0);
        $display("[TB] start and write during stream");
        applyStimulus(3, 1'b0, 0, 0, 1'b1, 0);
        applyStimulus(3, 1'b0, 0, 0, 1'b0, 0);
        $display("[TB] clamp");
        for (int i = 3; i < 64; i++)
            writeEntry(i, 32'h4100_0000 | 32'(i), 32'h4200_0000 | 32'(i), 32'h4300_0000 | 32'(i));
        applyStimulus(100, 1'b0, 0, 0, 1'b0, 0);
        $display("[TB] reset mid-stream");
        applyStimulus(3, 1'b0, 0, 0, 1'b0, 2);
        applyStimulus(3, 1'b0, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
